// File: rtl/tb_dina_seq_pkg.sv
// Shared codes for the TB write-port burst sequencer: source and direction
// encodings, FSM states and the mapper select builder.
package tb_dina_seq_pkg;

    localparam int unsigned SRC_W = 1;
    localparam int unsigned DIR_W = 2;
    localparam int unsigned SEL_W = SRC_W + DIR_W;

    typedef enum logic {
        TBa_CBa        = 1'b0,
        TBa_non_linear = 1'b1
    } src_e;

    typedef enum logic [DIR_W-1:0] {
        DIR_IDLE = 2'b00,
        DIR_POS  = 2'b01,
        DIR_NEG  = 2'b10,
        DIR_NEW  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Mapper select is the concatenation {src, dir}.
    function automatic logic [SEL_W-1:0] mk_sel(input logic src, input logic [DIR_W-1:0] dir);
        return {src, dir};
    endfunction

endpackage

// File: rtl/tb_seq_delay_line.sv
// Shift register carrying per-beat {valid, sel, l_k_0, addr, last} from the
// read strobe to the select tap and the final write stage.
module tb_seq_delay_line
    import tb_dina_seq_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAP   = 0
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] tap_o,
    output logic [W-1:0] q_o,
    output logic         pend_o
);

    logic [W-1:0] stg_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    // A beat is still pending while any stage ahead of the write stage is valid.
    always_comb begin
        pend_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            pend_o = pend_o | stg_q[i][W-1];
        end
    end

    assign tap_o = stg_q[TAP];
    assign q_o   = stg_q[DEPTH-1];

endmodule

// File: rtl/tb_dina_seq.sv
// Burst sequencer: issues source reads for one command and aligns the mapper
// select and TB write controls with the returned data.
module tb_dina_seq
    import tb_dina_seq_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned TB_DINA_SEL_DW = 3
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_src,
    input  logic [1:0]                cmd_dir,
    input  logic                      cmd_l_k_0,
    input  logic [ADDR_W-1:0]         cmd_rd_base,
    input  logic [ADDR_W-1:0]         cmd_wr_base,
    input  logic [LEN_W-1:0]          cmd_len,
    output logic                      CB_ena,
    output logic [ADDR_W-1:0]         CB_addra,
    output logic                      nl_rd_en,
    output logic [TB_DINA_SEL_DW-1:0] TB_dina_sel,
    output logic                      l_k_0,
    output logic                      TB_wea,
    output logic [ADDR_W-1:0]         TB_addra,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned DEPTH   = RD_LAT + 1;
    localparam int unsigned PW      = TB_DINA_SEL_DW + ADDR_W + 3;
    localparam int unsigned LAST_B  = 0;
    localparam int unsigned ADDR_LO = 1;
    localparam int unsigned LK0_B   = ADDR_W + 1;
    localparam int unsigned SEL_LO  = ADDR_W + 2;
    localparam int unsigned VALID_B = PW - 1;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                src_q, src_d;
    logic [1:0]          dir_q, dir_d;
    logic                lk0_q, lk0_d;
    logic                cb_ena_q, cb_ena_d;
    logic                nl_en_q, nl_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;

    logic                      issue;
    logic [TB_DINA_SEL_DW-1:0] beat_sel;
    logic [PW-1:0]             dl_d, dl_tap, dl_out;
    logic                      dl_pend;
    logic                      unused_dl;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            src_q     <= 1'b0;
            dir_q     <= '0;
            lk0_q     <= 1'b0;
            cb_ena_q  <= 1'b0;
            nl_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            dir_q     <= dir_d;
            lk0_q     <= lk0_d;
            cb_ena_q  <= cb_ena_d;
            nl_en_q   <= nl_en_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // cnt_q counts beats still to issue after the one currently on the strobe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src_d     = src_q;
        dir_d     = dir_q;
        lk0_d     = lk0_q;
        cb_ena_d  = 1'b0;
        nl_en_d   = 1'b0;
        rd_addr_d = '0;
        wr_addr_d = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    src_d = cmd_src;
                    dir_d = cmd_dir;
                    lk0_d = cmd_l_k_0;
                    if (cmd_len == '0 || cmd_dir == DIR_IDLE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_ISSUE;
                        cnt_d     = cmd_len - LEN_W'(1);
                        cb_ena_d  = (cmd_src == TBa_CBa);
                        nl_en_d   = (cmd_src == TBa_non_linear);
                        rd_addr_d = cmd_rd_base;
                        wr_addr_d = cmd_wr_base;
                    end
                end
            end
            S_ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d     = cnt_q - LEN_W'(1);
                    cb_ena_d  = ~src_q;
                    nl_en_d   = src_q;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!dl_pend) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Fields are zeroed for empty slots so idle stages present select 000.
    assign issue    = cb_ena_q | nl_en_q;
    assign beat_sel = issue ? TB_DINA_SEL_DW'(mk_sel(src_q, dir_q)) : TB_DINA_SEL_DW'(0);
    assign dl_d     = {issue, beat_sel, issue & lk0_q, wr_addr_q, issue & (cnt_q == '0)};

    tb_seq_delay_line #(
        .W     (PW),
        .DEPTH (DEPTH),
        .TAP   (RD_LAT - 1)
    ) u_dl (
        .clk    (clk),
        .clr_i  (sys_rst),
        .d_i    (dl_d),
        .tap_o  (dl_tap),
        .q_o    (dl_out),
        .pend_o (dl_pend)
    );

    assign unused_dl = ^{dl_tap[VALID_B], dl_tap[ADDR_LO +: ADDR_W], dl_tap[LAST_B],
                         dl_out[SEL_LO +: TB_DINA_SEL_DW], dl_out[LK0_B]};

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign CB_ena      = cb_ena_q;
    assign CB_addra    = rd_addr_q;
    assign nl_rd_en    = nl_en_q;
    assign TB_dina_sel = dl_tap[SEL_LO +: TB_DINA_SEL_DW];
    assign l_k_0       = dl_tap[LK0_B];
    assign TB_wea      = dl_out[VALID_B];
    assign TB_addra    = dl_out[ADDR_LO +: ADDR_W];
    assign done        = dl_out[LAST_B] | (state_q == S_DONE);

endmodule

// File: tb/tb_tb_dina_seq.sv
// Scoreboard bench for tb_dina_seq: RD_LAT=1 and RD_LAT=3 instances, expected
// strobes/selects/writes/done queued at accept and matched as they appear.
module tb_tb_dina_seq;
    import tb_dina_seq_pkg::*;

    localparam int unsigned AW  = 10;
    localparam int unsigned LW  = 8;
    localparam int unsigned SW  = 3;
    localparam int          BIG = 1 << 30;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
        logic          lk0;
        logic          nl;
    } exp_t;

    logic clk;
    logic rst1, rst3, v1, v3, act3;
    logic          c_src, c_lk0;
    logic [1:0]    c_dir;
    logic [AW-1:0] c_rd, c_wr;
    logic [LW-1:0] c_len;

    logic          o1_ready, o1_cb_ena, o1_nl_en, o1_lk0, o1_wea, o1_busy, o1_done;
    logic [AW-1:0] o1_cb_addr, o1_tb_addr;
    logic [SW-1:0] o1_sel;
    logic          o3_ready, o3_cb_ena, o3_nl_en, o3_lk0, o3_wea, o3_busy, o3_done;
    logic [AW-1:0] o3_cb_addr, o3_tb_addr;
    logic [SW-1:0] o3_sel;

    logic          m_ready, m_cb_ena, m_nl_en, m_lk0, m_wea, m_done;
    logic [AW-1:0] m_cb_addr, m_tb_addr;
    logic [SW-1:0] m_sel;

    exp_t q_rd[$], q_sel[$], q_wr[$];
    int   q_done[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    tb_dina_seq #(.ADDR_W(AW), .LEN_W(LW), .RD_LAT(1), .TB_DINA_SEL_DW(SW)) u_dut1 (
        .clk(clk), .sys_rst(rst1), .cmd_valid(v1), .cmd_ready(o1_ready),
        .cmd_src(c_src), .cmd_dir(c_dir), .cmd_l_k_0(c_lk0),
        .cmd_rd_base(c_rd), .cmd_wr_base(c_wr), .cmd_len(c_len),
        .CB_ena(o1_cb_ena), .CB_addra(o1_cb_addr), .nl_rd_en(o1_nl_en),
        .TB_dina_sel(o1_sel), .l_k_0(o1_lk0), .TB_wea(o1_wea), .TB_addra(o1_tb_addr),
        .busy(o1_busy), .done(o1_done)
    );

    tb_dina_seq #(.ADDR_W(AW), .LEN_W(LW), .RD_LAT(3), .TB_DINA_SEL_DW(SW)) u_dut3 (
        .clk(clk), .sys_rst(rst3), .cmd_valid(v3), .cmd_ready(o3_ready),
        .cmd_src(c_src), .cmd_dir(c_dir), .cmd_l_k_0(c_lk0),
        .cmd_rd_base(c_rd), .cmd_wr_base(c_wr), .cmd_len(c_len),
        .CB_ena(o3_cb_ena), .CB_addra(o3_cb_addr), .nl_rd_en(o3_nl_en),
        .TB_dina_sel(o3_sel), .l_k_0(o3_lk0), .TB_wea(o3_wea), .TB_addra(o3_tb_addr),
        .busy(o3_busy), .done(o3_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        m_ready   = act3 ? o3_ready   : o1_ready;
        m_cb_ena  = act3 ? o3_cb_ena  : o1_cb_ena;
        m_nl_en   = act3 ? o3_nl_en   : o1_nl_en;
        m_cb_addr = act3 ? o3_cb_addr : o1_cb_addr;
        m_sel     = act3 ? o3_sel     : o1_sel;
        m_lk0     = act3 ? o3_lk0     : o1_lk0;
        m_wea     = act3 ? o3_wea     : o1_wea;
        m_tb_addr = act3 ? o3_tb_addr : o1_tb_addr;
        m_done    = act3 ? o3_done    : o1_done;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Match every DUT output event against the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (m_cb_ena || m_nl_en) begin
            if (q_rd.size() == 0) check_eq("rd_extra", m_cb_ena | m_nl_en, 0);
            else begin
                e = q_rd.pop_front();
                check_eq("rd_cyc", cyc, e.cyc);
                check_eq("rd_nl", m_nl_en, e.nl);
                check_eq("rd_cb", m_cb_ena, !e.nl);
                if (!e.nl) check_eq("rd_addr", m_cb_addr, e.addr);
            end
        end
        if (m_sel != '0) begin
            if (q_sel.size() == 0) check_eq("sel_extra", m_sel, 0);
            else begin
                e = q_sel.pop_front();
                check_eq("sel_cyc", cyc, e.cyc);
                check_eq("sel_val", m_sel, e.sel);
                check_eq("sel_lk0", m_lk0, e.lk0);
            end
        end
        if (m_wea) begin
            if (q_wr.size() == 0) check_eq("wr_extra", m_wea, 0);
            else begin
                e = q_wr.pop_front();
                check_eq("wr_cyc", cyc, e.cyc);
                check_eq("wr_addr", m_tb_addr, e.addr);
            end
        end
        if (m_done) begin
            if (q_done.size() == 0) check_eq("done_extra", m_done, 0);
            else check_eq("done_cyc", cyc, q_done.pop_front());
        end
    end

    task automatic push_exp(input int t0, input int lat, input logic src, input logic [1:0] dir,
                            input logic lk0, input logic [AW-1:0] rd, input logic [AW-1:0] wr,
                            input int len, input int cut);
        exp_t e;
        if (len == 0 || dir == 2'b00) begin
            if (t0 + 1 < cut) q_done.push_back(t0 + 1);
            return;
        end
        for (int k = 0; k < len; k++) begin
            e.nl   = src;
            e.sel  = {src, dir};
            e.lk0  = lk0;
            e.cyc  = t0 + 1 + k;
            e.addr = rd + AW'(k);
            if (e.cyc < cut) q_rd.push_back(e);
            e.cyc = t0 + 1 + lat + k;
            if (e.cyc < cut) q_sel.push_back(e);
            e.cyc  = t0 + 2 + lat + k;
            e.addr = wr + AW'(k);
            if (e.cyc < cut) q_wr.push_back(e);
        end
        if (t0 + 1 + lat + len < cut) q_done.push_back(t0 + 1 + lat + len);
    endtask

    task automatic send(input logic d3, input logic src, input logic [1:0] dir, input logic lk0,
                        input logic [AW-1:0] rd, input logic [AW-1:0] wr, input logic [LW-1:0] len,
                        output int t0);
        int n;
        @(posedge clk); #1;
        act3 = d3;
        c_src = src; c_dir = dir; c_lk0 = lk0; c_rd = rd; c_wr = wr; c_len = len;
        if (d3) v3 = 1'b1; else v1 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_ready && n < 100);
        check_eq("accept", m_ready, 1);
        t0 = cyc;
    endtask

    task automatic release_cmd();
        @(posedge clk); #1;
        v1 = 1'b0;
        v3 = 1'b0;
    endtask

    task automatic drain(input int exp_rdy);
        int n;
        n = 0;
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready", m_ready, 1);
        if (exp_rdy >= 0) check_eq("ready_cyc", cyc, exp_rdy);
        repeat (3) @(negedge clk);
        check_eq("rd_left", q_rd.size(), 0);
        check_eq("sel_left", q_sel.size(), 0);
        check_eq("wr_left", q_wr.size(), 0);
        check_eq("done_left", q_done.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1;
        v1 = 0; v3 = 0; act3 = 0;
        c_src = 0; c_dir = 0; c_lk0 = 0; c_rd = 0; c_wr = 0; c_len = 0;
        rst1 = 1; rst3 = 1;
        repeat (3) @(posedge clk);
        #1;
        rst1 = 0; rst3 = 0;
        @(negedge clk);
        check_eq("rst_ready", o1_ready, 1);
        check_eq("rst_busy", o1_busy, 0);
        check_eq("rst_cb_ena", o1_cb_ena, 0);
        check_eq("rst_cb_addr", o1_cb_addr, 0);
        check_eq("rst_nl", o1_nl_en, 0);
        check_eq("rst_sel", o1_sel, 0);
        check_eq("rst_lk0", o1_lk0, 0);
        check_eq("rst_wea", o1_wea, 0);
        check_eq("rst_tb_addr", o1_tb_addr, 0);
        check_eq("rst_done", o1_done, 0);
        check_eq("rst3_ready", o3_ready, 1);

        // POS from CB, len 4
        send(0, 0, 2'b01, 0, 10'd5, 10'd20, 8'd4, t0);
        push_exp(t0, 1, 0, 2'b01, 0, 10'd5, 10'd20, 4, BIG);
        release_cmd();
        drain(t0 + 7);

        // NEW from non-linear unit, l_k_0 = 1, len 2
        send(0, 1, 2'b11, 1, 10'd100, 10'd50, 8'd2, t0);
        push_exp(t0, 1, 1, 2'b11, 1, 10'd100, 10'd50, 2, BIG);
        release_cmd();
        drain(t0 + 5);

        // len 0 followed immediately by a len 1 NEG command
        send(0, 0, 2'b01, 0, 10'd3, 10'd3, 8'd0, t0);
        push_exp(t0, 1, 0, 2'b01, 0, 10'd3, 10'd3, 0, BIG);
        send(0, 0, 2'b10, 0, 10'd7, 10'd9, 8'd1, t1);
        check_eq("b2b_accept", t1, t0 + 2);
        push_exp(t1, 1, 0, 2'b10, 0, 10'd7, 10'd9, 1, BIG);
        release_cmd();
        drain(t1 + 4);

        // illegal dir 00 behaves as len 0
        send(0, 0, 2'b00, 0, 10'd0, 10'd0, 8'd5, t0);
        push_exp(t0, 1, 0, 2'b00, 0, 10'd0, 10'd0, 5, BIG);
        release_cmd();
        drain(t0 + 2);

        // address wrap on both read and write sides
        send(0, 0, 2'b01, 0, 10'd1021, 10'd1022, 8'd4, t0);
        push_exp(t0, 1, 0, 2'b01, 0, 10'd1021, 10'd1022, 4, BIG);
        release_cmd();
        drain(t0 + 7);

        // reset at cycle 3 of a len 8 burst aborts it
        send(0, 0, 2'b01, 0, 10'd0, 10'd256, 8'd8, t0);
        push_exp(t0, 1, 0, 2'b01, 0, 10'd0, 10'd256, 8, t0 + 4);
        release_cmd();
        @(posedge clk); #1;
        check_eq("busy_mid", o1_busy, 1);
        @(posedge clk); #1;
        rst1 = 1;
        @(posedge clk); #1;
        rst1 = 0;
        @(negedge clk);
        check_eq("abort_cyc", cyc, t0 + 4);
        check_eq("abort_ready", o1_ready, 1);
        check_eq("abort_busy", o1_busy, 0);
        check_eq("abort_cb_ena", o1_cb_ena, 0);
        check_eq("abort_sel", o1_sel, 0);
        check_eq("abort_wea", o1_wea, 0);
        check_eq("abort_done", o1_done, 0);
        drain(-1);
        send(0, 0, 2'b01, 0, 10'd10, 10'd30, 8'd3, t0);
        push_exp(t0, 1, 0, 2'b01, 0, 10'd10, 10'd30, 3, BIG);
        release_cmd();
        drain(t0 + 6);

        // RD_LAT = 3, NEG len 3, next command held until ready returns
        send(1, 0, 2'b10, 0, 10'd40, 10'd60, 8'd3, t0);
        push_exp(t0, 3, 0, 2'b10, 0, 10'd40, 10'd60, 3, BIG);
        send(1, 0, 2'b01, 0, 10'd200, 10'd300, 8'd1, t1);
        check_eq("hold_accept", t1, t0 + 8);
        push_exp(t1, 3, 0, 2'b01, 0, 10'd200, 10'd300, 1, BIG);
        release_cmd();
        drain(t1 + 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tb_dina_seq.md
# tb_dina_seq

Burst sequencer for the TB write-port data mapper in the RSA datapath. It accepts one transfer command at a time, issues `len` consecutive source reads (CB port A or the non-linear unit), and drives the mapper's select and `l_k_0` controls aligned with the returned data. It then generates the TB write enable and address one cycle later, matching the mapper's registered output.

## Interface
- `ADDR_W`, 10, CB/TB row address width
- `LEN_W`, 8, burst length width
- `RD_LAT`, 1, source read latency in cycles (≥1), from read strobe to data at mapper input
- `TB_DINA_SEL_DW`, 3, mapper select width

Ports:
- `clk` in 1: single clock
- `sys_rst` in 1: synchronous, active-high reset
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`
- `cmd_src` in 1: 0 = CB, 1 = non-linear unit
- `cmd_dir` in 2: 01 POS, 10 NEG, 11 NEW; 00 is illegal and treated as a `len`=0 command
- `cmd_l_k_0` in 1: half select for NEW
- `cmd_rd_base` in ADDR_W: first source row
- `cmd_wr_base` in ADDR_W: first TB row
- `cmd_len` in LEN_W: beats
- `CB_ena` out 1: CB port A read strobe
- `CB_addra` out ADDR_W: CB read row
- `nl_rd_en` out 1: non-linear read strobe
- `TB_dina_sel` out TB_DINA_SEL_DW: `{src,dir}` to mapper
- `l_k_0` out 1: to mapper
- `TB_wea` out 1: TB write enable
- `TB_addra` out ADDR_W: TB write row
- `busy` out 1: not IDLE
- `done` out 1: one-cycle completion pulse

## Operation
- Reset values: all outputs 0, except `cmd_ready` = 1. State returns to IDLE and all delay-line stages are cleared.
- States:
  - IDLE: `cmd_ready` = 1. On accept, latch the command and go to ISSUE. If `len` = 0, go to DONE instead.
  - ISSUE: for beat k = 0..len-1, assert the source strobe (`CB_ena` if src=0, else `nl_rd_en`) with `CB_addra` = rd_base+k. After the last beat, go to DRAIN.
  - DRAIN: wait until the delay line is empty, then go to IDLE.
  - DONE: used only for `len`=0. Pulse `done`, then go to IDLE.
- Delay line: RD_LAT+1 stages, each carrying {valid, sel, l_k_0, wr_addr, last}.
  - Stage RD_LAT drives `TB_dina_sel`/`l_k_0`.
  - The final stage drives `TB_wea`/`TB_addra` = wr_base+k.
  - `done` = final-stage valid & last, in the same cycle as the last `TB_wea`.
- When no beat is at the select stage, `TB_dina_sel` = 3'b000 (mapper IDLE, outputs 0).
- Address arithmetic: base+k is modulo 2^ADDR_W, so it wraps silently.
- NEW: `l_k_0` is held constant for the whole burst. NEG reversal is done in the mapper; read addresses still ascend.
- `cmd_valid` while busy is ignored; the command is held by the requester.
- `sys_rst` mid-burst aborts immediately: no further strobes or writes, and no `done`.

## Timing
- Accept at cycle 0 (RD_LAT=1):
  - strobes in cycles 1..L
  - select valid in cycles 2..L+1
  - `TB_wea` in cycles 3..L+2
  - `done` at cycle L+2
  - `cmd_ready` = 1 again at cycle L+3
- General case: first `TB_wea` occurs RD_LAT+2 cycles after accept. Throughput is 1 beat/cycle, with no gaps within a burst.
- `len`=0: `done` at cycle 1, `cmd_ready` at cycle 2, no strobes or writes.
- Minimum command-to-command spacing is L+RD_LAT+2 cycles.

## Structure
- Shared package holds:
  - src codes (TBa_CBa=0, TBa_non_linear=1)
  - dir codes (IDLE/POS/NEG/NEW)
  - state encoding
- One sub-module, `tb_seq_delay_line`: a parameterised shift register of {valid, sel, l_k_0, addr, last} with a synchronous clear.

## Test plan
- POS, CB, rd_base=5, wr_base=20, len=4: `CB_addra` 5..8 in cycles 1–4; sel=3'b001 in cycles 2–5; `TB_wea` with addr 20..23 in cycles 3–6; `done` at cycle 6.
- NEW, non-linear, `l_k_0`=1, len=2: `nl_rd_en` ×2, `CB_ena` stays 0; sel=3'b111 and `l_k_0`=1 for 2 cycles; 2 writes.
- len=0: `done` at cycle 1, no `TB_wea`; a second command with len=1 is accepted at cycle 2.
- Wrap-around: wr_base=1022, len=4, ADDR_W=10: `TB_addra` = 1022, 1023, 0, 1.
- RD_LAT=3, NEG, len=3: first sel=3'b010 at cycle 4, `TB_wea` in cycles 5–7; `cmd_valid` held during the burst is not accepted until `cmd_ready` rises at cycle 8.
- `sys_rst` asserted at cycle 3 of a len=8 burst: next cycle all outputs 0 and `cmd_ready`=1; no `done`; a fresh command then completes normally.
